// File: rtl/camera_tx_pkg.sv
// Shared types for the OV7670-style pattern transmitter: FSM states, pattern
// selectors, colour-bar constants and the RGB565 byte split used on the bus.
package camera_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFRONT = 3'd5
  } tx_state_t;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_SOLID    = 2'd1,
    PAT_GRADIENT = 2'd2,
    PAT_CHECKER  = 2'd3
  } pattern_t;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  // First byte on the bus is {R,G[5:3]}, second is {G[2:0],B}.
  function automatic logic [7:0] rgb565_byte(input logic [15:0] rgb, input logic second);
    return second ? rgb[7:0] : rgb[15:8];
  endfunction

endpackage

// File: rtl/camera_pclk_gen.sv
// Free-running pixel clock divider: pclk toggles every PCLK_HALF system cycles
// and the tick outputs flag the system cycle on which pclk rises or falls.
module camera_pclk_gen #(
  parameter int PCLK_HALF = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_pclk,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int              DIV_W    = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PCLK_HALF - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_pclk;
  logic             w_wrap;

  assign w_wrap = (r_div == DIV_LAST);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_div  <= '0;
      r_pclk <= 1'b0;
    end else if (w_wrap) begin
      r_div  <= '0;
      r_pclk <= ~r_pclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

  assign o_pclk      = r_pclk;
  assign o_rise_tick = w_wrap & ~r_pclk;
  assign o_fall_tick = w_wrap &  r_pclk;

endmodule

// File: rtl/camera_pattern_tx.sv
// OV7670-style parallel camera transmitter (RGB565, two bytes per pixel) with test patterns.
// Optional CAMERA_TX_FRAME_TAG_EN stamps pixel (0,0) with {8'hA5, frame_cnt}.
module camera_pattern_tx #(
  parameter int PCLK_HALF   = 4,
  parameter int H_ACTIVE    = 320,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 240,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        enable_in,
  input  logic [1:0]  pattern_sel_in,
  input  logic [15:0] color_in,
  output logic        pclk_out,
  output logic        vsync_out,
  output logic        href_out,
  output logic [7:0]  pixel_out,
  output logic        frame_done_out,
  output logic        busy_out
);
  import camera_tx_pkg::*;

  localparam int LINE_PCLKS = 2 * H_ACTIVE + H_BLANK;
  localparam int X_W        = (LINE_PCLKS > 1) ? $clog2(LINE_PCLKS) : 1;
  localparam int Y_MAX_A    = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int Y_MAX_B    = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int Y_LINES    = (Y_MAX_A > Y_MAX_B) ? Y_MAX_A : Y_MAX_B;
  localparam int Y_W        = (Y_LINES > 1) ? $clog2(Y_LINES) : 1;

  localparam logic [X_W-1:0] X_LAST     = X_W'(LINE_PCLKS - 1);
  localparam logic [X_W-1:0] X_ACT_LAST = X_W'(2 * H_ACTIVE - 1);
  localparam logic [Y_W-1:0] VS_LAST    = Y_W'(VSYNC_LINES - 1);
  localparam logic [Y_W-1:0] VB_LAST    = Y_W'(V_BACK - 1);
  localparam logic [Y_W-1:0] VA_LAST    = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0] VF_LAST    = Y_W'(V_FRONT - 1);

  tx_state_t        r_state, w_state_nxt;
  logic [X_W-1:0]   r_x, w_x_nxt;
  logic [Y_W-1:0]   r_y, w_y_nxt;
  pattern_t         r_pattern;
  logic [15:0]      r_color;
  logic             r_vsync, r_href, r_busy, r_frame_done;
  logic [7:0]       r_pixel;
  logic             w_rise_tick, w_fall_tick;
  logic             w_line_end, w_latch, w_frame_end;
  logic [15:0]      w_px, w_py, w_rgb;
  logic [7:0]       w_pixel_nxt;
  logic             w_unused;

  camera_pclk_gen #(.PCLK_HALF(PCLK_HALF)) u_pclk_gen (
    .i_clk       (clk_in),
    .i_rst_n     (reset_n_in),
    .o_pclk      (pclk_out),
    .o_rise_tick (w_rise_tick),
    .o_fall_tick (w_fall_tick)
  );

`ifdef CAMERA_TX_FRAME_TAG_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk_in) begin
    if (!reset_n_in)                    r_frame_cnt <= '0;
    else if (w_fall_tick & w_frame_end) r_frame_cnt <= r_frame_cnt + 8'd1;
  end
`endif

  assign w_line_end = (r_x == X_LAST);

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x + 1'b1;
    w_y_nxt     = r_y;
    w_latch     = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_x_nxt = '0;
        if (enable_in) begin
          w_state_nxt = ST_VSYNC;
          w_latch     = 1'b1;
        end
      end
      ST_VSYNC, ST_VBACK: begin
        if (w_line_end) begin
          w_x_nxt = '0;
          if (r_y == ((r_state == ST_VSYNC) ? VS_LAST : VB_LAST)) begin
            w_y_nxt     = '0;
            w_state_nxt = (r_state == ST_VSYNC) ? ST_VBACK : ST_ACTIVE;
          end else begin
            w_y_nxt = r_y + 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        if (r_x == X_ACT_LAST) w_state_nxt = ST_HBLANK;
      end
      ST_HBLANK: begin
        if (w_line_end) begin
          w_x_nxt = '0;
          if (r_y == VA_LAST) begin
            w_y_nxt     = '0;
            w_state_nxt = ST_VFRONT;
          end else begin
            w_y_nxt     = r_y + 1'b1;
            w_state_nxt = ST_ACTIVE;
          end
        end
      end
      ST_VFRONT: begin
        if (w_line_end) begin
          w_x_nxt = '0;
          if (r_y == VF_LAST) begin
            w_y_nxt     = '0;
            w_frame_end = 1'b1;
            w_latch     = enable_in;
            w_state_nxt = enable_in ? ST_VSYNC : ST_IDLE;
          end else begin
            w_y_nxt = r_y + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_x_nxt     = '0;
        w_y_nxt     = '0;
      end
    endcase
  end

  // Pixel data is computed for the position being entered so the output register stays aligned.
  assign w_px = 16'(w_x_nxt >> 1);
  assign w_py = 16'(w_y_nxt);

  always_comb begin
    w_rgb = BAR_BLACK;
    case (r_pattern)
      PAT_BARS: begin
        case (w_px[8:6])
          3'd0:    w_rgb = BAR_WHITE;
          3'd1:    w_rgb = BAR_YELLOW;
          3'd2:    w_rgb = BAR_CYAN;
          3'd3:    w_rgb = BAR_GREEN;
          3'd4:    w_rgb = BAR_MAGENTA;
          default: w_rgb = BAR_BLACK;
        endcase
      end
      PAT_SOLID:    w_rgb = r_color;
      PAT_GRADIENT: w_rgb = {w_px[4:0], w_py[5:0], w_px[4:0]};
      PAT_CHECKER:  w_rgb = (w_px[4] ^ w_py[4]) ? BAR_WHITE : BAR_BLACK;
      default:      w_rgb = BAR_BLACK;
    endcase
`ifdef CAMERA_TX_FRAME_TAG_EN
    if (w_px == 16'd0 && w_py == 16'd0) w_rgb = {8'hA5, r_frame_cnt};
`endif
  end

  assign w_pixel_nxt = (w_state_nxt == ST_ACTIVE) ? rgb565_byte(w_rgb, w_x_nxt[0]) : 8'h00;

  // All timing rides the falling pclk edge; the rising-edge tick is not needed here.
  assign w_unused = &{1'b0, w_rise_tick, w_px[15:9], w_px[5], w_py[15:6]};

  // NOTE: every register, including latched pattern/colour, is reset so a mid-frame reset leaves no stale data.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      r_state      <= ST_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_pattern    <= PAT_BARS;
      r_color      <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_pixel      <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_fall_tick & w_frame_end;
      if (w_fall_tick) begin
        r_state <= w_state_nxt;
        r_x     <= w_x_nxt;
        r_y     <= w_y_nxt;
        if (w_latch) begin
          r_pattern <= pattern_t'(pattern_sel_in);
          r_color   <= color_in;
        end
        r_vsync <= (w_state_nxt == ST_VSYNC);
        r_href  <= (w_state_nxt == ST_ACTIVE);
        r_pixel <= w_pixel_nxt;
        r_busy  <= (w_state_nxt != ST_IDLE);
      end
    end
  end

  assign vsync_out      = r_vsync;
  assign href_out       = r_href;
  assign pixel_out      = r_pixel;
  assign frame_done_out = r_frame_done;
  assign busy_out       = r_busy;

endmodule
